// File: rtl/scrf_const_loader.sv
// Constant-register-file loader: streams 64-bit config words into the CRF write port,
// one word per cycle. Optional word parity checking is enabled by defining SCRF_LOADER_PARITY_EN.
module scrf_const_loader #(
    parameter int WRITE_AWIDTH = 5,
    parameter int WRITE_DWIDTH = 64,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    load_start,
    input  logic [WRITE_AWIDTH-1:0] load_base,
    input  logic [CNT_WIDTH-1:0]    load_words,
    input  logic                    load_abort,
    input  logic                    cfg_valid,
    input  logic [WRITE_DWIDTH-1:0] cfg_data,
    output logic                    cfg_ready,
    output logic                    Write_En,
    output logic [WRITE_AWIDTH-1:0] Write_Addr,
    output logic [WRITE_DWIDTH-1:0] In_Const,
    output logic                    load_busy,
    output logic                    load_done,
    output logic                    load_err
);

    localparam int AW = WRITE_AWIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    // Each word covers three consecutive entries: it needs addr..addr+2 in range.
    localparam logic [AW+1:0]        ADDR_MAX = {2'b00, {AW{1'b1}}};
    localparam logic [AW+1:0]        SPAN     = {{AW{1'b0}}, 2'b10};
    localparam logic [AW:0]          STRIDE   = {{(AW-1){1'b0}}, 2'b11};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

`ifdef SCRF_LOADER_PARITY_EN
    function automatic logic parity_ok(input logic [WRITE_DWIDTH-1:0] w);
        logic [3:0] p;
        p = {^w[63:49], ^w[48:34], ^w[33:19], ^w[18:4]};
        return (p == w[3:0]);
    endfunction
`endif

    logic [1:0]              state_q, state_d;
    logic [AW:0]             addr_q, addr_d;
    logic [CNT_WIDTH-1:0]    rem_q, rem_d;
    logic                    we_q, we_d;
    logic [AW-1:0]           waddr_q, waddr_d;
    logic [WRITE_DWIDTH-1:0] const_q, const_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;

    logic [AW+1:0] span_end_s;
    logic          ovf_s;
    logic          rem_nz_s;
    logic          ready_s;
    logic          xfer_s;
    logic          word_ok_s;

    assign span_end_s = {1'b0, addr_q} + SPAN;
    assign ovf_s      = (span_end_s > ADDR_MAX);
    assign rem_nz_s   = (rem_q != CNT_ZERO);
    assign ready_s    = (state_q == ST_LOAD) && rem_nz_s && !ovf_s && !load_abort;
    assign xfer_s     = cfg_valid && ready_s;

`ifdef SCRF_LOADER_PARITY_EN
    assign word_ok_s = parity_ok(cfg_data);
`else
    assign word_ok_s = 1'b1;
`endif

    // Next-state, address/count bookkeeping and write-port staging
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        const_d = const_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    if (load_words != CNT_ZERO) begin
                        state_d = ST_LOAD;
                        addr_d  = {1'b0, load_base};
                        rem_d   = load_words;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // Abort and overflow both beat a pending transfer; cfg_ready is already low.
                if (load_abort || (rem_nz_s && ovf_s)) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else if (xfer_s && !word_ok_s) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else if (xfer_s) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q[AW-1:0];
                    const_d = cfg_data;
                    addr_d  = addr_q + STRIDE;
                    rem_d   = rem_q - CNT_ONE;
                    if (rem_q == CNT_ONE) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else if (!rem_nz_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_LOAD);
    end

    // State and registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            addr_q  <= {(AW+1){1'b0}};
            rem_q   <= CNT_ZERO;
            we_q    <= 1'b0;
            waddr_q <= {AW{1'b0}};
            const_q <= {WRITE_DWIDTH{1'b0}};
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            const_q <= const_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign cfg_ready  = ready_s;
    assign Write_En   = we_q;
    assign Write_Addr = waddr_q;
    assign In_Const   = const_q;
    assign load_busy  = busy_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule
